// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port ALU arbiter: operation codes and default datapath width.
package alu_arbiter_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      XOR  = 4'd2,
      OR   = 4'd3,
      AND  = 4'd4,
      SLL  = 4'd5,
      SRL  = 4'd6,
      SRA  = 4'd7,
      SLT  = 4'd8,
      SLTU = 4'd9
   } aluOperations;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requester ports; master = requester side, slave = arbiter side.
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) ();

   logic             req0_valid;
   logic             req0_ready;
   aluOperations     req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_data;

   logic             req1_valid;
   logic             req1_ready;
   aluOperations     req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_data;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_data,
      input  req1_ready, rsp1_valid, rsp1_data
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_data,
      output req1_ready, rsp1_valid, rsp1_data
   );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Combinational ALU shared by both requester ports; wrap-around arithmetic, no flags.
module alu_core
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  aluOperations     op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      y = '0;
      case (op)
         ADD:  y = a + b;
         SUB:  y = a - b;
         XOR:  y = a ^ b;
         OR:   y = a | b;
         AND:  y = a & b;
         SLL:  y = a << shamt;
         SRL:  y = a >> shamt;
         SRA:  y = $unsigned($signed(a) >>> shamt);
         SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
         // undefined codes fall through to zero
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two ports, with a single registered result slot.
//   state | meaning
//   IDLE  | result register empty, any valid request can be accepted
//   HOLD  | result register full, presented on the owner's response channel
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   logic             owner;
   logic             prio;
   logic             rsp0_valid_q;
   logic             rsp1_valid_q;
   logic [WIDTH-1:0] rsp0_data_q;
   logic [WIDTH-1:0] rsp1_data_q;

   logic             owner_rdy;
   logic             can_accept;
   logic             grant;
   logic             accept;
   aluOperations     alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;

   always_comb begin
      owner_rdy  = owner ? bus.rsp1_ready : bus.rsp0_ready;
      can_accept = (state == IDLE) || owner_rdy;
      if (bus.req0_valid && bus.req1_valid) grant = prio;
      else                                  grant = bus.req1_valid;
      accept = !reset && can_accept && (bus.req0_valid || bus.req1_valid);
   end

   assign bus.req0_ready = accept && !grant;
   assign bus.req1_ready = accept && grant;

   assign alu_op = grant ? bus.req1_op : bus.req0_op;
   assign alu_a  = grant ? bus.req1_a  : bus.req0_a;
   assign alu_b  = grant ? bus.req1_b  : bus.req0_b;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .op (alu_op),
      .a  (alu_a),
      .b  (alu_b),
      .y  (alu_y)
   );

   // Response outputs are the result register itself, split per port so the
   // non-owner channel reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= 1'b0;
         prio         <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else if (accept) begin
         state        <= HOLD;
         owner        <= grant;
         prio         <= ~grant;
         rsp0_valid_q <= ~grant;
         rsp1_valid_q <= grant;
         rsp0_data_q  <= grant ? '0 : alu_y;
         rsp1_data_q  <= grant ? alu_y : '0;
      end else if (state == HOLD && owner_rdy) begin
         state        <= IDLE;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end
   end

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Reference model: one result slot, its owner, and the tie-break pointer.
   bit          m_full  = 1'b0;
   int          m_owner = 0;
   logic [31:0] m_data  = '0;
   int          m_prio  = 0;

   function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      int s;
      s = int'(b & 32'd31);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a ^ b;
         4'd3: return a | b;
         4'd4: return a & b;
         4'd5: return a << s;
         4'd6: return a >> s;
         4'd7: return (a >> s) | ((a & 32'h8000_0000) != 0 ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd9: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Port the model expects to be accepted this cycle, -1 if none.
   function automatic int exp_grant();
      bit can;
      if (reset) return -1;
      can = !m_full || (m_owner == 0 ? bus.rsp0_ready : bus.rsp1_ready);
      if (!can) return -1;
      if (bus.req0_valid && bus.req1_valid) return m_prio;
      if (bus.req0_valid) return 0;
      if (bus.req1_valid) return 1;
      return -1;
   endfunction

   task automatic tick();
      int          g;
      bit          drain;
      logic [31:0] nd;
      g     = exp_grant();
      drain = m_full && (m_owner == 0 ? bus.rsp0_ready : bus.rsp1_ready);
      nd    = (g == 1) ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b)
                       : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
      @(posedge clk);
      if (reset) begin
         m_full = 0; m_owner = 0; m_data = '0; m_prio = 0;
      end else if (g >= 0) begin
         m_full = 1; m_owner = g; m_data = nd; m_prio = 1 - g;
      end else if (drain) begin
         m_full = 0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 0; bus.req0_op = ADD; bus.req0_a = '0; bus.req0_b = '0; bus.rsp0_ready = 0;
      bus.req1_valid = 0; bus.req1_op = ADD; bus.req1_a = '0; bus.req1_b = '0; bus.rsp1_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      bus.req0_valid = 1; bus.req1_valid = 1;
      bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      tick();
      #1;
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b/%b required 0/0", bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
          bus.rsp0_data !== 32'h0 || bus.rsp1_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rsp: got v=%b/%b d=%h/%h required 0", bus.rsp0_valid, bus.rsp1_valid,
                  bus.rsp0_data, bus.rsp1_data);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      bus.req0_valid = 1; bus.req0_op = ADD; bus.req0_a = 5; bus.req0_b = 7; bus.rsp0_ready = 1;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_ready: got %b/%b required 1/0", bus.req0_ready, bus.req1_ready);
      end
      tick();
      bus.req0_valid = 0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'd12 || bus.rsp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: got v0=%b d0=%h v1=%b required 1/0000000c/0",
                  bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid);
      end
      tick();
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp0_data !== 32'h0) begin
         errors++;
         $display("FAIL single_drain: got v0=%b d0=%h required 0/0", bus.rsp0_valid, bus.rsp0_data);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.req0_valid = 1; bus.req0_op = SUB; bus.req0_a = 3; bus.req0_b = 5; bus.rsp0_ready = 1;
      bus.req1_valid = 1; bus.req1_op = SRA; bus.req1_a = 32'h8000_0000; bus.req1_b = 4; bus.rsp1_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got %b/%b required %b/%b", i, bus.req0_ready,
                     bus.req1_ready, i % 2 == 0, i % 2 == 1);
         end
         tick();
         checks++;
         if (i % 2 == 0) begin
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'hFFFF_FFFE || bus.rsp1_valid !== 1'b0) begin
               errors++;
               $display("FAIL rr_rsp0[%0d]: got v0=%b d0=%h v1=%b required 1/fffffffe/0", i,
                        bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid);
            end
         end else begin
            if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'hF800_0000 ||
                bus.rsp0_valid !== 1'b0 || bus.rsp0_data !== 32'h0) begin
               errors++;
               $display("FAIL rr_rsp1[%0d]: got v1=%b d1=%h v0=%b d0=%h required 1/f8000000/0/0", i,
                        bus.rsp1_valid, bus.rsp1_data, bus.rsp0_valid, bus.rsp0_data);
            end
         end
      end
      idle_inputs();
      bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req1_valid = 1; bus.req1_op = SLT; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 1;
      tick();
      bus.req1_valid = 0;
      bus.req0_valid = 1; bus.req0_op = ADD; bus.req0_a = 2; bus.req0_b = 3; bus.rsp0_ready = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall[%0d]: req0_ready got %b required 0", i, bus.req0_ready);
         end
         checks++;
         if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'd1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v1=%b d1=%h required 1/00000001", i,
                     bus.rsp1_valid, bus.rsp1_data);
         end
         tick();
      end
      bus.rsp1_ready = 1;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: req0_ready got %b required 1", bus.req0_ready);
      end
      tick();
      bus.req0_valid = 0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'd5 || bus.rsp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_next: got v0=%b d0=%h v1=%b required 1/00000005/0",
                  bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      aluOperations ops [3];
      logic [31:0]  av  [3];
      logic [31:0]  bv  [3];
      logic [31:0]  exp [3];
      ops = '{SLTU, SLL, SRL};
      av  = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
      bv  = '{32'd1, 32'd31, 32'd31};
      exp = '{32'd0, 32'h8000_0000, 32'd1};
      do_reset();
      bus.rsp0_ready = 1;
      for (int i = 0; i < 3; i++) begin
         bus.req0_valid = 1; bus.req0_op = ops[i]; bus.req0_a = av[i]; bus.req0_b = bv[i];
         #1;
         checks++;
         if (bus.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b required 1", i, bus.req0_ready);
         end
         tick();
         checks++;
         if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== exp[i]) begin
            errors++;
            $display("FAIL b2b_rsp[%0d]: got v0=%b d0=%h required 1/%h", i,
                     bus.rsp0_valid, bus.rsp0_data, exp[i]);
         end
      end
      bus.req0_valid = 0;
      tick();
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      bus.req0_valid = 1; bus.req0_op = XOR; bus.req0_a = 32'hF0F0; bus.req0_b = 32'h0FF0;
      tick();
      bus.req0_valid = 0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'hFF00) begin
         errors++;
         $display("FAIL hold_before_reset: got v0=%b d0=%h required 1/0000ff00",
                  bus.rsp0_valid, bus.rsp0_data);
      end
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp0_data !== 32'h0) begin
         errors++;
         $display("FAIL hold_after_reset: got v0=%b d0=%h required 0/0", bus.rsp0_valid, bus.rsp0_data);
      end
      bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL tie_after_reset: got %b/%b required 1/0", bus.req0_ready, bus.req1_ready);
      end
      tick();
      idle_inputs();
      bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      tick();
   endtask

   task automatic test_shift_mask();
      do_reset();
      bus.req0_valid = 1; bus.req0_op = SLL; bus.req0_a = 1; bus.req0_b = 33; bus.rsp0_ready = 1;
      tick();
      bus.req0_valid = 0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'd2) begin
         errors++;
         $display("FAIL shift_mask: got v0=%b d0=%h required 1/00000002", bus.rsp0_valid, bus.rsp0_data);
      end
      tick();
   endtask

   task automatic test_random();
      bit pend0 = 0;
      bit pend1 = 0;
      int g;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!pend0) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req0_op    = aluOperations'(4'($urandom_range(0, 15)));
            bus.req0_a     = $urandom;
            bus.req0_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         if (!pend1) begin
            bus.req1_valid = ($urandom_range(0, 2) == 0);
            bus.req1_op    = aluOperations'(4'($urandom_range(0, 15)));
            bus.req1_a     = $urandom;
            bus.req1_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         bus.rsp0_ready = ($urandom_range(0, 2) != 0);
         bus.rsp1_ready = ($urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 99) == 0);
         #1;
         g = exp_grant();
         checks++;
         if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
            errors++;
            $display("FAIL rand_grant[%0d]: got %b/%b required %b/%b", i,
                     bus.req0_ready, bus.req1_ready, g == 0, g == 1);
         end
         pend0 = bus.req0_valid && (g != 0) && !reset;
         pend1 = bus.req1_valid && (g != 1) && !reset;
         tick();
         checks++;
         if (bus.rsp0_valid !== (m_full && m_owner == 0) ||
             bus.rsp1_valid !== (m_full && m_owner == 1) ||
             bus.rsp0_data  !== ((m_full && m_owner == 0) ? m_data : 32'h0) ||
             bus.rsp1_data  !== ((m_full && m_owner == 1) ? m_data : 32'h0)) begin
            errors++;
            $display("FAIL rand_rsp[%0d]: got v=%b/%b d=%h/%h required full=%0d owner=%0d data=%h", i,
                     bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data,
                     m_full, m_owner, m_data);
         end
      end
      reset = 0;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_in_hold();
      test_shift_mask();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
